// File: rtl/usb_stream_in_feeder_if.sv
// Bus bundle between the capture-side producer, the elastic feeder and
// the usb_stream_in consumer. master = producer/consumer side, slave = feeder.
interface usb_stream_in_feeder_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  consume;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic [ADDR_WIDTH:0]   level;
   logic                  burst_ready;
   logic                  overflow;
   logic                  underflow;
   logic                  clear_errors;

   modport master (
      output in_data, in_valid, consume, clear_errors,
      input  in_ready, data_out, data_valid, level, burst_ready, overflow, underflow
   );

   modport slave (
      input  in_data, in_valid, consume, clear_errors,
      output in_ready, data_out, data_valid, level, burst_ready, overflow, underflow
   );
endinterface

// File: rtl/usb_stream_in_feeder.sv
// First-word-fall-through elastic FIFO feeding usb_stream_in.
// The oldest word lives in a registered head (data_out); the remaining
// level-1 words live in a circular buffer that refills the head on a pop,
// so a consume every cycle streams one word per clock.
module usb_stream_in_feeder #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 9,
   parameter int BURST_WORDS = 4
) (
   input logic                clk,
   input logic                rst_n,
   usb_stream_in_feeder_if.slave bus
);

   localparam int                DEPTH   = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] BURST_L = (ADDR_WIDTH + 1)'(BURST_WORDS);
   localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH + 1)'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   level_q;
   logic [ADDR_WIDTH:0]   level_next;
   logic [DATA_WIDTH-1:0] head_q;
   logic [DATA_WIDTH-1:0] head_next;
   logic                  head_valid_q;
   logic                  head_valid_next;
   logic                  ready_q;
   logic                  burst_q;
   logic                  overflow_q;
   logic                  underflow_q;

   logic push;
   logic pop;
   logic mem_empty;
   logic mem_wr;
   logic mem_rd;
   logic head_from_in;

   assign push      = bus.in_valid & ready_q;
   assign pop       = bus.consume & head_valid_q;
   // Everything beyond the head is in the buffer, so level <= 1 means it is empty.
   assign mem_empty = (level_q <= ONE_L);

   // Steer each word: into the head when it would otherwise be empty, else into the buffer.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      level_next      = level_q;
      head_next       = head_q;
      head_valid_next = head_valid_q;
      head_from_in    = push & (~head_valid_q | (pop & mem_empty));
      mem_wr          = push & ~head_from_in;
      mem_rd          = pop & ~mem_empty;

      unique case ({push, pop})
         2'b10:   level_next = level_q + ONE_L;
         2'b01:   level_next = level_q - ONE_L;
         default: level_next = level_q;
      endcase

      if (head_from_in) begin
         head_next       = bus.in_data;
         head_valid_next = 1'b1;
      end else if (mem_rd) begin
         head_next       = mem[rd_ptr];
         head_valid_next = 1'b1;
      end else if (pop) begin
         // Last word left: head keeps its stale value, only the valid drops.
         head_valid_next = 1'b0;
      end
   end

   // State, pointers, registered status and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level_q      <= '0;
         head_q       <= '0;
         head_valid_q <= 1'b0;
         ready_q      <= 1'b0;
         burst_q      <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         level_q      <= level_next;
         head_q       <= head_next;
         head_valid_q <= head_valid_next;
         ready_q      <= (level_next < DEPTH_L);
         burst_q      <= (level_next >= BURST_L);
         if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
         if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
         // A new error event in the same cycle as a clear wins.
         if (bus.in_valid & ~ready_q)           overflow_q <= 1'b1;
         else if (bus.clear_errors)             overflow_q <= 1'b0;
         if (bus.consume & ~head_valid_q)       underflow_q <= 1'b1;
         else if (bus.clear_errors)             underflow_q <= 1'b0;
      end
   end

   // Buffer storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; the pointers and level define which entries are live.
      if (mem_wr) mem[wr_ptr] <= bus.in_data;
   end

   assign bus.in_ready    = ready_q;
   assign bus.data_out    = head_q;
   assign bus.data_valid  = head_valid_q;
   assign bus.level       = level_q;
   assign bus.burst_ready = burst_q;
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_usb_stream_in_feeder.sv
// Scoreboard bench for usb_stream_in_feeder: stimulus queues expected words,
// a negedge monitor compares data_out whenever a pop is about to register.
module tb_usb_stream_in_feeder;

   localparam int DW = 32;
   localparam int AW = 9;
   localparam int DEPTH = 512;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;

   logic [DW-1:0] sb[$];

   usb_stream_in_feeder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   usb_stream_in_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WORDS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      sb.push_back(w);
   endtask

   // Monitor: a pop registers at the next posedge, so compare the head now.
   always @(negedge clk) begin
      if (rst_n && bus.consume && bus.data_valid) begin
         if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL sb_underrun: got 0x%0h with no word expected", bus.data_out);
         end else begin
            check("data_out", 64'(bus.data_out), 64'(sb.pop_front()));
         end
      end
   end

   // Watchdog bounds the whole run.
   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, tests %0d", tests_run);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "timeout");
   end

   initial begin
      bus.in_data      = '0;
      bus.in_valid     = 1'b0;
      bus.consume      = 1'b0;
      bus.clear_errors = 1'b0;

      // Reset state
      #12;
      check("rst_in_ready",   64'(bus.in_ready), 0);
      check("rst_data_valid", 64'(bus.data_valid), 0);
      check("rst_level",      64'(bus.level), 0);
      check("rst_burst",      64'(bus.burst_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("in_ready_after_rst", 64'(bus.in_ready), 1);

      // Three words, FWFT latency and level
      push_word(32'h30);
      tick();
      check("fwft_data",  64'(bus.data_out), 64'h30);
      check("fwft_valid", 64'(bus.data_valid), 1);
      push_word(32'h100);
      tick();
      push_word(32'h007F007F);
      tick();
      bus.in_valid = 1'b0;
      check("level3", 64'(bus.level), 3);
      check("burst_at3", 64'(bus.burst_ready), 0);
      push_word(32'h00800080);
      tick();
      bus.in_valid = 1'b0;
      check("level4", 64'(bus.level), 4);
      check("burst_at4", 64'(bus.burst_ready), 1);

      // Back-to-back drain of four
      bus.consume = 1'b1;
      tick();
      check("burst_after_pop", 64'(bus.burst_ready), 0);
      check("level_after_pop", 64'(bus.level), 3);
      tick();
      tick();
      tick();
      bus.consume = 1'b0;
      check("drain_valid", 64'(bus.data_valid), 0);
      check("drain_level", 64'(bus.level), 0);
      check("drain_hold",  64'(bus.data_out), 64'h00800080);

      // Fill to depth, then overflow
      for (int i = 0; i < DEPTH; i++) begin
         push_word(DW'(i));
         tick();
      end
      check("full_level", 64'(bus.level), DEPTH);
      check("full_in_ready", 64'(bus.in_ready), 0);
      bus.in_data = 32'hDEADBEEF;
      tick();
      bus.in_valid = 1'b0;
      check("overflow_set", 64'(bus.overflow), 1);
      check("overflow_level", 64'(bus.level), DEPTH);
      bus.clear_errors = 1'b1;
      tick();
      bus.clear_errors = 1'b0;
      check("overflow_clr", 64'(bus.overflow), 0);
      bus.consume = 1'b1;
      tick();
      check("ready_after_full_pop", 64'(bus.in_ready), 1);
      for (int i = 1; i < DEPTH; i++) tick();
      bus.consume = 1'b0;
      check("full_drain_level", 64'(bus.level), 0);
      check("full_drain_udf", 64'(bus.underflow), 0);

      // Steady push+pop at level 1
      push_word(32'd1000);
      tick();
      bus.consume = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         push_word(DW'(2000 + i));
         tick();
         check("stream_level", 64'(bus.level), 1);
      end
      bus.in_valid = 1'b0;
      tick();
      bus.consume = 1'b0;
      check("stream_end_level", 64'(bus.level), 0);
      check("stream_end_valid", 64'(bus.data_valid), 0);

      // Underflow and clear priority
      bus.consume = 1'b1;
      tick();
      bus.consume = 1'b0;
      check("udf_set", 64'(bus.underflow), 1);
      check("udf_level", 64'(bus.level), 0);
      check("udf_valid", 64'(bus.data_valid), 0);
      bus.clear_errors = 1'b1;
      tick();
      bus.clear_errors = 1'b0;
      check("udf_clr", 64'(bus.underflow), 0);
      bus.clear_errors = 1'b1;
      bus.consume = 1'b1;
      tick();
      bus.clear_errors = 1'b0;
      bus.consume = 1'b0;
      check("udf_set_wins", 64'(bus.underflow), 1);
      bus.clear_errors = 1'b1;
      tick();
      bus.clear_errors = 1'b0;

      // Async reset mid-drain at level 7
      for (int i = 0; i < 9; i++) begin
         push_word(32'hA000_0000 + DW'(i));
         tick();
      end
      bus.in_valid = 1'b0;
      bus.consume = 1'b1;
      tick();
      tick();
      check("pre_rst_level", 64'(bus.level), 7);
      #1;
      rst_n = 1'b0;
      bus.consume = 1'b0;
      sb.delete();
      #1;
      check("arst_data_out", 64'(bus.data_out), 0);
      check("arst_valid",    64'(bus.data_valid), 0);
      check("arst_level",    64'(bus.level), 0);
      check("arst_ready",    64'(bus.in_ready), 0);
      check("arst_burst",    64'(bus.burst_ready), 0);
      check("arst_ovf",      64'(bus.overflow), 0);
      check("arst_udf",      64'(bus.underflow), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("arst_ready_rise", 64'(bus.in_ready), 1);
      push_word(32'hCAFE0001);
      tick();
      bus.in_valid = 1'b0;
      bus.consume = 1'b1;
      tick();
      bus.consume = 1'b0;
      check("post_rst_level", 64'(bus.level), 0);

      tick();
      check("sb_empty", 64'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
